// File: rtl/fifo_rgb565_reader_pkg.sv
// pixel_pkg: types and constants shared by the camera byte-FIFO reader.
// Holds the RGB565 field widths, the default frame geometry, the byte-phase
// enum and the tag struct that travels with every pixel through the skid buffer.
// No ports: this is a package.
package pixel_pkg;

    localparam int R_W   = 5;
    localparam int G_W   = 6;
    localparam int B_W   = 5;
    localparam int PIX_W = R_W + G_W + B_W;

    localparam int H_ACTIVE_DEF = 640;
    localparam int V_ACTIVE_DEF = 480;
    localparam int X_W_DEF      = 10;
    localparam int Y_W_DEF      = 9;

    // Which half of a pixel the next captured byte belongs to.
    typedef enum logic {
        PH_HI = 1'b0,
        PH_LO = 1'b1
    } phase_t;

    // One pixel plus its coordinates and frame markers.
    typedef struct packed {
        logic [PIX_W-1:0]   data;
        logic [X_W_DEF-1:0] x;
        logic [Y_W_DEF-1:0] y;
        logic               sof;
        logic               eol;
        logic               eof;
    } pix_tag_t;

endpackage

// File: rtl/fifo_rgb565_reader_if.sv
// fifo_rgb565_reader_if: tagged RGB565 pixel stream (valid/ready).
// Signals: pix_valid / pix_ready handshake, pix_data (RGB565), pix_x / pix_y
// coordinates, pix_sof / pix_eol / pix_eof frame markers.
// master = pixel source (the reader), slave = downstream consumer.
interface fifo_rgb565_reader_if import pixel_pkg::*; #(
    parameter int X_W = X_W_DEF,
    parameter int Y_W = Y_W_DEF
);
    logic             pix_valid;
    logic             pix_ready;
    logic [PIX_W-1:0] pix_data;
    logic [X_W-1:0]   pix_x;
    logic [Y_W-1:0]   pix_y;
    logic             pix_sof;
    logic             pix_eol;
    logic             pix_eof;

    modport master (
        output pix_valid, pix_data, pix_x, pix_y, pix_sof, pix_eol, pix_eof,
        input  pix_ready
    );

    modport slave (
        input  pix_valid, pix_data, pix_x, pix_y, pix_sof, pix_eol, pix_eof,
        output pix_ready
    );
endinterface

// File: rtl/fifo_rgb565_reader_pix_skid2.sv
// pix_skid2: two-entry valid/ready buffer holding pixel tags.
// Ports: clk, rst (async active-low), push/din (write side, caller guarantees
// room), ready (downstream accept), valid/dout (head entry), occ (0..2 entries,
// used by the reader's read-credit calculation).
module pix_skid2 import pixel_pkg::*; (
    input  logic     clk,
    input  logic     rst,
    input  logic     push,
    input  pix_tag_t din,
    input  logic     ready,
    output logic     valid,
    output pix_tag_t dout,
    output logic [1:0] occ
);

    pix_tag_t   ent0;
    pix_tag_t   ent1;
    logic [1:0] count;
    logic       pop;

    assign pop   = (count != 2'd0) && ready;
    assign valid = (count != 2'd0);
    assign dout  = ent0;
    assign occ   = count;

    // ent0 is always the head; a pop shifts ent1 forward so the head never
    // changes while the consumer is stalling.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ent0  <= '0;
            ent1  <= '0;
            count <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) begin
                        ent0 <= din;
                    end else if (count == 2'd1) begin
                        ent1 <= din;
                    end
                    if (count != 2'd2) begin
                        count <= count + 2'd1;
                    end
                end
                2'b01: begin
                    ent0  <= ent1;
                    count <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        ent0 <= din;
                    end else begin
                        ent0 <= ent1;
                        ent1 <= din;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: rtl/fifo_rgb565_reader.sv
// fifo_rgb565_reader: drains the 8-bit camera byte FIFO, pairs bytes into
// RGB565 pixels (high byte first), tags them with x/y and sof/eol/eof, and
// offers them on a valid/ready stream.
// Ports: clk, rst (async active-low), frame_sync (1-cycle frame start pulse),
// fifo_empty / fifo_do / fifo_re (FIFO read side, data one cycle after re),
// drop_cnt (bytes discarded by frame_sync, saturating), pix (pixel stream).
module fifo_rgb565_reader import pixel_pkg::*; #(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int X_W      = X_W_DEF,
    parameter int Y_W      = Y_W_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_sync,
    input  logic        fifo_empty,
    input  logic [7:0]  fifo_do,
    output logic        fifo_re,
    output logic [15:0] drop_cnt,
    fifo_rgb565_reader_if.master pix
);

    phase_t         phase;
    phase_t         phase_next;
    logic           rd_q;
    logic [7:0]     hi_reg;
    logic [X_W-1:0] x_cnt;
    logic [Y_W-1:0] y_cnt;
    logic           push;
    pix_tag_t       push_tag;
    pix_tag_t       head;
    logic           out_valid;
    logic [1:0]     occ;
    logic           pop;
    logic           inflight;
    logic           next_lo;
    logic [2:0]     credit_need;
    logic           at_eol;
    logic           at_last_line;
    logic [1:0]     drop_inc;
    logic [16:0]    drop_sum;

    assign at_eol       = (x_cnt == X_W'(H_ACTIVE - 1));
    assign at_last_line = (y_cnt == Y_W'(V_ACTIVE - 1));
    assign pop          = out_valid && pix.pix_ready;

    // Byte phase register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase <= PH_HI;
        end else begin
            phase <= phase_next;
        end
    end

    // Phase advance and pixel push; frame_sync throws away whatever byte is
    // returning and restarts on a high byte.
    always_comb begin
        phase_next = phase;
        push       = 1'b0;
        if (frame_sync) begin
            phase_next = PH_HI;
        end else if (rd_q) begin
            if (phase == PH_HI) begin
                phase_next = PH_LO;
            end else begin
                phase_next = PH_HI;
                push       = 1'b1;
            end
        end
    end

    // Read credit: count buffer slots already owned (stored entries, a LO byte
    // on its way back, and the byte we would issue now if it completes a pixel)
    // against the two-entry buffer, crediting a same-cycle pop. The byte being
    // issued is the opposite phase of a returning byte, else the current phase.
    always_comb begin
        inflight    = rd_q && (phase == PH_LO);
        next_lo     = rd_q ? (phase == PH_HI) : (phase == PH_LO);
        credit_need = {1'b0, occ} + {2'b00, inflight} + {2'b00, next_lo};
        fifo_re     = rst && !fifo_empty && !frame_sync &&
                      (credit_need <= (3'd2 + {2'b00, pop}));
    end

    // Tag and saturating drop-count arithmetic.
    always_comb begin
        push_tag.data = {hi_reg, fifo_do};
        push_tag.x    = X_W_DEF'(x_cnt);
        push_tag.y    = Y_W_DEF'(y_cnt);
        push_tag.sof  = (x_cnt == '0) && (y_cnt == '0);
        push_tag.eol  = at_eol;
        push_tag.eof  = at_eol && at_last_line;
        drop_inc      = {1'b0, rd_q} + {1'b0, (phase == PH_LO)};
        drop_sum      = {1'b0, drop_cnt} + {15'd0, drop_inc};
    end

    // Read pipeline, high-byte hold, coordinates and drop counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_q     <= 1'b0;
            hi_reg   <= 8'd0;
            x_cnt    <= '0;
            y_cnt    <= '0;
            drop_cnt <= 16'd0;
        end else begin
            rd_q <= fifo_re;
            if (!frame_sync && rd_q && (phase == PH_HI)) begin
                hi_reg <= fifo_do;
            end
            if (frame_sync) begin
                x_cnt    <= '0;
                y_cnt    <= '0;
                drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
            end else if (push) begin
                if (at_eol) begin
                    x_cnt <= '0;
                    y_cnt <= at_last_line ? '0 : (y_cnt + Y_W'(1));
                end else begin
                    x_cnt <= x_cnt + X_W'(1);
                end
            end
        end
    end

    pix_skid2 u_skid (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (push_tag),
        .ready (pix.pix_ready),
        .valid (out_valid),
        .dout  (head),
        .occ   (occ)
    );

    assign pix.pix_valid = out_valid;
    assign pix.pix_data  = head.data;
    assign pix.pix_x     = X_W'(head.x);
    assign pix.pix_y     = Y_W'(head.y);
    assign pix.pix_sof   = head.sof;
    assign pix.pix_eol   = head.eol;
    assign pix.pix_eof   = head.eof;

endmodule

// File: tb/tb_fifo_rgb565_reader.sv
// tb_fifo_rgb565_reader: randomized bench for fifo_rgb565_reader with a small
// 4x2 frame so line and frame wrap happen quickly. A byte-source model feeds
// the FIFO port; a pairing model builds the expected tagged pixel queue.
module tb_fifo_rgb565_reader;

    localparam int H  = 4;
    localparam int V  = 2;
    localparam int XW = 10;
    localparam int YW = 9;

    typedef struct packed {
        logic [15:0] data;
        logic [9:0]  x;
        logic [8:0]  y;
        logic        sof;
        logic        eol;
        logic        eof;
    } exp_pix_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        frame_sync = 1'b0;
    logic        force_empty = 1'b0;
    logic        fifo_empty;
    logic        fifo_re;
    logic [7:0]  fifo_do = 8'd0;
    logic [15:0] drop_cnt;

    fifo_rgb565_reader_if #(.X_W(XW), .Y_W(YW)) pix ();

    fifo_rgb565_reader #(
        .H_ACTIVE (H),
        .V_ACTIVE (V),
        .X_W      (XW),
        .Y_W      (YW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .frame_sync (frame_sync),
        .fifo_empty (fifo_empty),
        .fifo_do    (fifo_do),
        .fifo_re    (fifo_re),
        .drop_cnt   (drop_cnt),
        .pix        (pix)
    );

    always #5 clk = ~clk;

    // Byte source standing in for the camera FIFO.
    logic [7:0] src_mem [0:511];
    int wr_idx = 0;
    int rd_idx = 0;

    assign fifo_empty = force_empty || (rd_idx >= wr_idx);

    always @(posedge clk) begin
        if (fifo_re) begin
            fifo_do <= src_mem[rd_idx];
            rd_idx  <= rd_idx + 1;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic applyStimulus(input int n);
        for (int i = 0; i < n; i++) begin
            src_mem[wr_idx] = 8'($urandom);
            wr_idx++;
        end
    endtask

    // Reference: bytes arrive one cycle after a read; two arrivals make a
    // pixel at the current raster position; frame_sync discards the held
    // byte and the arriving one and restarts the raster.
    exp_pix_t   exp_q[$];
    int         mx = 0;
    int         my = 0;
    int         mdrop = 0;
    logic       held_v = 1'b0;
    logic       re_m = 1'b0;
    logic [7:0] held_b = 8'd0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            re_m   <= 1'b0;
            held_v <= 1'b0;
            mx     <= 0;
            my     <= 0;
            mdrop  <= 0;
            exp_q.delete();
        end else begin
            re_m <= fifo_re;
            if (frame_sync) begin
                mdrop  <= (mdrop + int'(re_m) + int'(held_v) > 65535) ? 65535
                          : mdrop + int'(re_m) + int'(held_v);
                held_v <= 1'b0;
                mx     <= 0;
                my     <= 0;
            end else if (re_m) begin
                if (!held_v) begin
                    held_v <= 1'b1;
                    held_b <= fifo_do;
                end else begin
                    held_v <= 1'b0;
                    exp_q.push_back('{data: {held_b, fifo_do}, x: 10'(mx), y: 9'(my),
                                      sof: (mx == 0 && my == 0), eol: (mx == H - 1),
                                      eof: (mx == H - 1 && my == V - 1)});
                    if (mx == H - 1) begin
                        mx <= 0;
                        my <= (my == V - 1) ? 0 : my + 1;
                    end else begin
                        mx <= mx + 1;
                    end
                end
            end
        end
    end

    // Monitor, sampled on the falling edge.
    int       cyc = 0;
    int       re_count = 0;
    int       first_re = -1;
    int       second_re = -1;
    int       first_valid = -1;
    int       xfers = 0;
    int       eol_seen = 0;
    int       eof_seen = 0;
    logic     prev_stall = 1'b0;
    exp_pix_t prev_head;
    exp_pix_t got;
    exp_pix_t want;
    exp_pix_t last_got = '0;

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            got.data = pix.pix_data;
            got.x    = pix.pix_x;
            got.y    = pix.pix_y;
            got.sof  = pix.pix_sof;
            got.eol  = pix.pix_eol;
            got.eof  = pix.pix_eof;
            if (fifo_empty) begin
                checkOutput("re_while_empty", 64'(fifo_re), 64'(0));
            end
            if (rst) begin
                checkOutput("drop_cnt", 64'(drop_cnt), 64'(mdrop[15:0]));
                if (fifo_re) begin
                    re_count++;
                    if (first_re < 0) first_re = cyc;
                    else if (second_re < 0) second_re = cyc;
                end
                if (pix.pix_valid && first_valid < 0) first_valid = cyc;
                if (prev_stall) begin
                    checkOutput("head_hold", 64'({pix.pix_valid, got}), 64'({1'b1, prev_head}));
                end
                if (pix.pix_valid && pix.pix_ready) begin
                    if (exp_q.size() == 0) begin
                        checkOutput("extra_pixel", 64'(1), 64'(0));
                    end else begin
                        want = exp_q.pop_front();
                        checkOutput("pixel", 64'(got), 64'(want));
                    end
                    xfers++;
                    if (got.eol) eol_seen++;
                    if (got.eof) eof_seen++;
                    last_got = got;
                end
                prev_stall = pix.pix_valid && !pix.pix_ready;
                prev_head  = got;
            end else begin
                prev_stall = 1'b0;
            end
        end
    end

    task automatic waitXfers(input int n, input int budget);
        int k = 0;
        while (xfers < n && k < budget) begin
            @(posedge clk);
            k++;
        end
        if (xfers < n) checkOutput("timeout_xfers", 64'(xfers), 64'(n));
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog expired t=%0t", $time);
        $fatal(1, "[TB] watchdog");
    end

    int base;
    int base_re;
    int eol0;
    int eof0;
    int drop0;
    int k;

    initial begin
        // Reset and first pixel.
        pix.pix_ready = 1'b1;
        rst = 1'b0;
        src_mem[0] = 8'h12;
        src_mem[1] = 8'h34;
        wr_idx = 2;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_re", 64'(fifo_re), 64'(0));
        checkOutput("reset_valid", 64'(pix.pix_valid), 64'(0));
        checkOutput("reset_drop", 64'(drop_cnt), 64'(0));
        @(posedge clk);
        #1 rst = 1'b1;
        waitXfers(1, 20);
        checkOutput("first_latency", 64'(first_valid - first_re), 64'(3));
        checkOutput("re_back_to_back", 64'(second_re - first_re), 64'(1));
        checkOutput("first_pixel", 64'(last_got), 64'({16'h1234, 10'd0, 9'd0, 1'b1, 1'b0, 1'b0}));

        // Line and frame wrap, starting from an idle frame_sync.
        @(posedge clk);
        #1 frame_sync = 1'b1;
        @(posedge clk);
        #1 frame_sync = 1'b0;
        base = xfers;
        eol0 = eol_seen;
        eof0 = eof_seen;
        applyStimulus(18);
        waitXfers(base + 9, 100);
        checkOutput("wrap_eol_count", 64'(eol_seen - eol0), 64'(2));
        checkOutput("wrap_eof_count", 64'(eof_seen - eof0), 64'(1));
        checkOutput("wrap_restart", 64'({last_got.x, last_got.y, last_got.sof}), 64'({10'd0, 9'd0, 1'b1}));

        // Backpressure.
        @(posedge clk);
        #1 pix.pix_ready = 1'b0;
        base_re = re_count;
        base = xfers;
        applyStimulus(20);
        repeat (20) @(posedge clk);
        checkOutput("stall_reads", 64'(re_count - base_re), 64'(5));
        #1 pix.pix_ready = 1'b1;
        waitXfers(base + 10, 200);

        // FIFO gaps with random downstream ready.
        base = xfers;
        applyStimulus(24);
        for (int i = 0; i < 400 && xfers < base + 12; i++) begin
            @(posedge clk);
            #1 force_empty = ~force_empty;
            pix.pix_ready = 1'($urandom_range(0, 1));
        end
        force_empty = 1'b0;
        pix.pix_ready = 1'b1;
        waitXfers(base + 12, 50);

        // frame_sync with a high byte held and the next byte returning.
        @(posedge clk);
        #1 pix.pix_ready = 1'b0;
        base_re = re_count;
        base = xfers;
        drop0 = mdrop;
        applyStimulus(6);
        k = 0;
        while (re_count < base_re + 4 && k < 20) begin
            @(negedge clk);
            #1;
            k++;
        end
        if (re_count < base_re + 4) checkOutput("fs_timeout", 64'(re_count - base_re), 64'(4));
        @(posedge clk);
        #1 frame_sync = 1'b1;
        @(posedge clk);
        #1 frame_sync = 1'b0;
        @(negedge clk);
        checkOutput("fs_drop", 64'(drop_cnt), 64'(16'(drop0 + 2)));
        repeat (5) @(posedge clk);
        #1 pix.pix_ready = 1'b1;
        waitXfers(base + 2, 50);
        checkOutput("fs_new_frame", 64'({last_got.data, last_got.x, last_got.y, last_got.sof}),
                    64'({src_mem[wr_idx - 2], src_mem[wr_idx - 1], 10'd0, 9'd0, 1'b1}));

        // Asynchronous reset with the output buffer full.
        @(posedge clk);
        #1 pix.pix_ready = 1'b0;
        applyStimulus(10);
        repeat (15) @(posedge clk);
        @(negedge clk);
        checkOutput("pre_reset_valid", 64'(pix.pix_valid), 64'(1));
        #2 rst = 1'b0;
        #1;
        checkOutput("async_valid", 64'(pix.pix_valid), 64'(0));
        checkOutput("async_re", 64'(fifo_re), 64'(0));
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        pix.pix_ready = 1'b1;
        checkOutput("post_reset_drop", 64'(drop_cnt), 64'(0));
        base = xfers;
        waitXfers(base + 1, 20);
        checkOutput("post_reset_first", 64'({last_got.x, last_got.y, last_got.sof}), 64'({10'd0, 9'd0, 1'b1}));

        repeat (5) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_rgb565_reader.md
Name: fifo_rgb565_reader

Overview:
- Drains the 8-bit camera byte FIFO on its read side.
- Pairs consecutive bytes into RGB565 pixels, high byte first.
- Tags each pixel with x/y coordinates and start-of-frame, end-of-line and end-of-frame markers.
- Presents the pixels through a valid/ready stream to the downstream gesture-processing pipeline.
- Same clock as the FIFO; it replaces the ad-hoc read logic around the FIFO.

Parameters:
- H_ACTIVE, 640, pixels per line.
- V_ACTIVE, 480, lines per frame.
- X_W, 10, width of pix_x; must satisfy 2^X_W >= H_ACTIVE.
- Y_W, 9, width of pix_y; must satisfy 2^Y_W >= V_ACTIVE.

Ports:
- clk  in  1  system clock; the FIFO's read and write clocks use this same clock.
- rst  in  1  asynchronous, active-low reset.
- frame_sync  in  1  one-cycle pulse at frame start, from the camera vsync edge already synchronised to clk.
- fifo_empty  in  1  FIFO empty_flag.
- fifo_do  in  8  FIFO read data; valid the cycle after fifo_re.
- fifo_re  out  1  FIFO read enable.
- pix_valid  out  1  pixel available.
- pix_ready  in  1  downstream accepts the pixel.
- pix_data  out  16  RGB565 pixel = {first byte, second byte}.
- pix_x  out  X_W  column of pix_data.
- pix_y  out  Y_W  row of pix_data.
- pix_sof  out  1  high with pixel (0,0).
- pix_eol  out  1  high with pixel x = H_ACTIVE-1.
- pix_eof  out  1  high with pixel (H_ACTIVE-1, V_ACTIVE-1).
- drop_cnt  out  16  count of bytes discarded by frame_sync; saturates at 0xFFFF.

Behaviour:
- Reset (rst = 0, asynchronous) clears everything: fifo_re, pix_valid, pix_data, pix_x, pix_y, all flags, drop_cnt, phase (= HI) and the output buffer.
- FIFO read timing:
  - fifo_re in cycle t delivers a byte on fifo_do at t+1.
  - rd_q is fifo_re delayed one cycle and marks the byte to capture.
  - fifo_re is never asserted while fifo_empty = 1.
- Byte phase, two states, HI and LO:
  - HI: the captured byte goes into hi_reg; phase moves to LO.
  - LO: {hi_reg, byte} plus the current coordinates and flags are pushed into a 2-entry output FIFO (skid buffer); phase moves to HI.
- Coordinates are attached at push:
  - x increments on each pixel; at H_ACTIVE-1, x wraps to 0 and y increments.
  - At (H_ACTIVE-1, V_ACTIVE-1), x and y both wrap to 0; the next frame starts without needing frame_sync.
- Credit rule:
  - occ = output buffer entries (0..2).
  - inflight = 1 when rd_q = 1 and that byte is a LO byte.
  - fifo_re = !fifo_empty && (occ + inflight + (next issued byte is LO ? 1 : 0) - (pix_valid && pix_ready) <= 2).
  - The output buffer never overflows.
  - With pix_ready held at 1, sustained throughput is 1 byte per cycle (1 pixel per 2 cycles).
- Output stream:
  - pix_valid = (occ != 0). Outputs come from the head entry.
  - Transfer happens on pix_valid && pix_ready.
  - While pix_valid = 1 and pix_ready = 0, the head entry stays stable.
  - A push and a pop in the same cycle leave occ unchanged.
- Latency: first fifo_re to pix_valid = 3 cycles (re, HI capture, LO re+capture, push registered).
- frame_sync (synchronous, highest priority):
  - Phase returns to HI; x and y clear to 0.
  - fifo_re is forced low that cycle.
  - Any byte returning that cycle (rd_q) is discarded.
  - drop_cnt increments by 1 for a discarded in-flight byte, plus 1 if a HI byte was held.
  - Entries already in the output buffer are kept and delivered with their original tags.
  - frame_sync together with rst = 0: reset wins.
- No wait on frame_sync after reset: the first byte after reset is a HI byte at (0,0).

Decomposition:
- Shared package pixel_pkg:
  - RGB565 field widths (R = 5, G = 6, B = 5).
  - Defaults for H_ACTIVE and V_ACTIVE.
  - Pixel-tag struct {data, x, y, sof, eol, eof}.
- One natural sub-module, pix_skid2: a 2-entry valid/ready buffer holding the tag struct, with occupancy output for the credit rule.

Test Plan:
1. Reset and first pixel: rst low, FIFO holds 0x12, 0x34, pix_ready = 1; release reset -> fifo_re in two consecutive cycles; pix_valid with pix_data = 0x1234, x = 0, y = 0, pix_sof = 1, 3 cycles after the first fifo_re.
2. Line and frame wrap: H_ACTIVE = 4, V_ACTIVE = 2, 16 bytes, pix_ready = 1 -> 8 pixels; pix_eol on x = 3 (pixels 4 and 8); pix_eof only on pixel 8; bytes 17/18 come out as (0,0) with pix_sof = 1.
3. Backpressure: pix_ready = 0 for 20 cycles with a full FIFO -> at most 5 reads (2 pixels buffered plus 1 HI byte); head pix_data stable; no drop. Raise pix_ready -> pixels arrive in order with no duplicates.
4. Empty gaps: toggle fifo_empty every cycle -> fifo_re never high while fifo_empty = 1; pixel sequence correct.
5. Mid-pixel frame_sync: pulse after 3 bytes (HI byte held), 4th byte in flight -> drop_cnt = 2; next two bytes form a pixel at (0,0) with pix_sof = 1; the already-buffered pixel is delivered unchanged.
6. Async reset mid-stream: drop rst asynchronously with occ = 2 -> pix_valid and fifo_re go 0 immediately without waiting for a clock edge; after release, x = 0, y = 0, drop_cnt = 0.
